// File: rtl/alu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_pkg                                                            |
// | Opcode encodings and FSM state encoding shared by the seq_alu      |
// | top level and its iterative multiply/divide engine.                |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package alu_pkg;

  localparam logic [5:0] OP_ADD  = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h01;
  localparam logic [5:0] OP_SUB  = 6'h02;
  localparam logic [5:0] OP_AND  = 6'h03;
  localparam logic [5:0] OP_ANDI = 6'h04;
  localparam logic [5:0] OP_SLL  = 6'h05;
  localparam logic [5:0] OP_SRL  = 6'h06;
  localparam logic [5:0] OP_DIV  = 6'h15;
  localparam logic [5:0] OP_MULT = 6'h16;
  localparam logic [5:0] OP_NAND = 6'h22;
  localparam logic [5:0] OP_XOR  = 6'h23;
  localparam logic [5:0] OP_NOP  = 6'h3F;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_alu_iter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seq_alu_iter                                                       |
// | Iterative engine: unsigned shift-add multiply or restoring divide, |
// | one bit per clock, WIDTH iterations after the start edge.          |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module seq_alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             hi_nonzero,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  // hi/lo hold {product high, product low / multiplier} for MULT and
  // {partial remainder, dividend-shifting-into-quotient} for DIV.
  logic             active;
  logic             div_mode;
  logic             dz;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] opnd;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] hi_next;
  logic [WIDTH-1:0] lo_next;

  assign mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
  assign div_shift = {hi, lo[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd};
  assign div_ge    = ~div_diff[WIDTH];

  // Next-iteration datapath, selected by the captured operation type
  always_comb begin
    hi_next = hi;
    lo_next = lo;
    if (div_mode) begin
      hi_next = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      lo_next = {lo[WIDTH-2:0], div_ge};
    end else begin
      hi_next = mul_sum[WIDTH:1];
      lo_next = {mul_sum[0], lo[WIDTH-1:1]};
    end
  end

  // The final iteration's values are exposed combinationally so the top
  // level latches them on the same edge the counter reaches WIDTH.
  assign done        = active && (cnt == CNT_W'(WIDTH - 1));
  assign result      = lo_next;
  assign hi_nonzero  = |hi_next;
  assign div_by_zero = dz;

  // Operand capture on start, then one iteration per clock while active
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active   <= 1'b0;
      div_mode <= 1'b0;
      dz       <= 1'b0;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      opnd     <= '0;
    end else if (start) begin
      active   <= 1'b1;
      div_mode <= is_div;
      dz       <= (b == '0);
      cnt      <= '0;
      hi       <= '0;
      lo       <= is_div ? a : b;
      opnd     <= is_div ? b : a;
    end else if (active) begin
      hi  <= hi_next;
      lo  <= lo_next;
      cnt <= cnt + CNT_W'(1);
      if (done) begin
        active <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seq_alu                                                            |
// | Registered ALU with valid/ready operand handshake, single-cycle    |
// | arithmetic/logic/shift ops, iterative MULT/DIV and sticky N/Z/V.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       op,
  input  logic [WIDTH-1:0] alu_in1,
  input  logic [WIDTH-1:0] alu_in2,
  output logic [WIDTH-1:0] alu_out,
  output logic             out_valid,
  output logic             n_flag,
  output logic             z_flag,
  output logic             v_flag,
  output logic             busy
);

  localparam int SH_W = $clog2(WIDTH);

  state_t           state;

  logic             accept;
  logic             iter_start;
  logic             iter_is_div;
  logic             iter_done;
  logic             iter_hi_nz;
  logic             iter_dz;
  logic [WIDTH-1:0] iter_result;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             shift_oob;
  logic [WIDTH-1:0] sc_res;
  logic             sc_v;
  logic             upd_out;
  logic             upd_nz;
  logic             upd_v;
  logic [WIDTH-1:0] md_res;
  logic             md_v;

  assign accept      = in_valid && in_ready;
  assign iter_is_div = (op == OP_DIV);
  assign iter_start  = accept && ((op == OP_MULT) || (op == OP_DIV));

  assign sum       = alu_in1 + alu_in2;
  assign diff      = alu_in1 - alu_in2;
  assign shift_oob = (alu_in2 >= WIDTH'(WIDTH));

  seq_alu_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk         (clk),
    .rst         (rst),
    .start       (iter_start),
    .is_div      (iter_is_div),
    .a           (alu_in1),
    .b           (alu_in2),
    .done        (iter_done),
    .result      (iter_result),
    .hi_nonzero  (iter_hi_nz),
    .div_by_zero (iter_dz)
  );

  // Divide by zero forces an all-ones quotient; V is div-by-zero for DIV
  // and a non-zero upper product half for MULT.
  assign md_res = ((state == ST_DIV) && iter_dz) ? '1 : iter_result;
  assign md_v   = (state == ST_DIV) ? iter_dz : iter_hi_nz;

  // Single-cycle result and which of alu_out / N,Z / V it is allowed to touch
  always_comb begin
    sc_res  = '0;
    sc_v    = 1'b0;
    upd_out = 1'b0;
    upd_nz  = 1'b0;
    upd_v   = 1'b0;
    case (op)
      OP_ADD, OP_ADDI: begin
        sc_res  = sum;
        sc_v    = (alu_in1[WIDTH-1] == alu_in2[WIDTH-1]) &&
                  (sum[WIDTH-1] != alu_in1[WIDTH-1]);
        upd_out = 1'b1;
        upd_nz  = 1'b1;
        upd_v   = 1'b1;
      end
      OP_SUB: begin
        sc_res  = diff;
        sc_v    = (alu_in1[WIDTH-1] != alu_in2[WIDTH-1]) &&
                  (diff[WIDTH-1] != alu_in1[WIDTH-1]);
        upd_out = 1'b1;
        upd_nz  = 1'b1;
        upd_v   = 1'b1;
      end
      OP_AND, OP_ANDI: begin
        sc_res  = alu_in1 & alu_in2;
        upd_out = 1'b1;
        upd_nz  = 1'b1;
        upd_v   = 1'b1;
      end
      OP_NAND: begin
        sc_res  = ~(alu_in1 & alu_in2);
        upd_out = 1'b1;
        upd_nz  = 1'b1;
        upd_v   = 1'b1;
      end
      OP_XOR: begin
        sc_res  = alu_in1 ^ alu_in2;
        upd_out = 1'b1;
        upd_nz  = 1'b1;
        upd_v   = 1'b1;
      end
      OP_SLL: begin
        sc_res  = shift_oob ? '0 : (alu_in1 << alu_in2[SH_W-1:0]);
        upd_out = 1'b1;
      end
      OP_SRL: begin
        sc_res  = shift_oob ? '0 : (alu_in1 >> alu_in2[SH_W-1:0]);
        upd_out = 1'b1;
      end
      default: begin
        sc_res = '0;
      end
    endcase
  end

  // Control FSM with registered handshake, result and sticky flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      alu_out   <= '0;
      n_flag    <= 1'b0;
      z_flag    <= 1'b0;
      v_flag    <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          out_valid <= 1'b0;
          if (accept) begin
            in_ready <= 1'b0;
            if (op == OP_MULT) begin
              state <= ST_MUL;
              busy  <= 1'b1;
            end else if (op == OP_DIV) begin
              state <= ST_DIV;
              busy  <= 1'b1;
            end else begin
              state     <= ST_DONE;
              out_valid <= 1'b1;
              if (upd_out) begin
                alu_out <= sc_res;
              end
              if (upd_nz) begin
                n_flag <= sc_res[WIDTH-1];
                z_flag <= (sc_res == '0);
              end
              if (upd_v) begin
                v_flag <= sc_v;
              end
            end
          end
        end
        ST_MUL, ST_DIV: begin
          if (iter_done) begin
            state     <= ST_DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            alu_out   <= md_res;
            n_flag    <= md_res[WIDTH-1];
            z_flag    <= (md_res == '0);
            v_flag    <= md_v;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_seq_alu                                                         |
// | Directed self-checking bench for seq_alu at WIDTH=32 and WIDTH=16. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_seq_alu;

  localparam logic [5:0] T_ADD  = 6'h00;
  localparam logic [5:0] T_ADDI = 6'h01;
  localparam logic [5:0] T_SUB  = 6'h02;
  localparam logic [5:0] T_AND  = 6'h03;
  localparam logic [5:0] T_ANDI = 6'h04;
  localparam logic [5:0] T_SLL  = 6'h05;
  localparam logic [5:0] T_SRL  = 6'h06;
  localparam logic [5:0] T_DIV  = 6'h15;
  localparam logic [5:0] T_MULT = 6'h16;
  localparam logic [5:0] T_NAND = 6'h22;
  localparam logic [5:0] T_XOR  = 6'h23;
  localparam logic [5:0] T_NOP  = 6'h3F;

  logic        clk;
  logic        rst;

  logic        in_valid;
  logic        in_ready;
  logic [5:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] alu_out;
  logic        out_valid;
  logic        n_flag;
  logic        z_flag;
  logic        v_flag;
  logic        busy;

  logic        in_valid_h;
  logic        in_ready_h;
  logic [5:0]  op_h;
  logic [15:0] a_h;
  logic [15:0] b_h;
  logic [15:0] alu_out_h;
  logic        out_valid_h;
  logic        n_flag_h;
  logic        z_flag_h;
  logic        v_flag_h;
  logic        busy_h;

  int checks;
  int failures;

  seq_alu #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .alu_in1(a), .alu_in2(b), .alu_out(alu_out), .out_valid(out_valid),
    .n_flag(n_flag), .z_flag(z_flag), .v_flag(v_flag), .busy(busy)
  );

  seq_alu #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid_h), .in_ready(in_ready_h), .op(op_h),
    .alu_in1(a_h), .alu_in2(b_h), .alu_out(alu_out_h), .out_valid(out_valid_h),
    .n_flag(n_flag_h), .z_flag(z_flag_h), .v_flag(v_flag_h), .busy(busy_h)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one operation on the 32-bit DUT and wait for its result.
  // lat is 1 for a result in the cycle right after the accept edge, -1 on timeout.
  // With poke set, in_valid is pulsed with junk operands while waiting.
  task automatic op32(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y,
                      input bit poke, output int lat, output bit rdy_seen);
    int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 60) begin
      rdy_seen |= in_ready;
      if (poke) begin
        in_valid = 1'b1; op = T_ADD; a = $urandom; b = $urandom;
      end
      @(posedge clk); #1; lat++;
    end
    in_valid = 1'b0;
    if (!out_valid) lat = -1;
  endtask

  task automatic op16(input logic [5:0] o, input logic [15:0] x, input logic [15:0] y,
                      output int lat);
    int guard;
    guard = 0;
    while (!in_ready_h && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    op_h = o; a_h = x; b_h = y; in_valid_h = 1'b1;
    @(posedge clk); #1;
    in_valid_h = 1'b0;
    lat = 1;
    while (!out_valid_h && lat < 60) begin
      @(posedge clk); #1; lat++;
    end
    if (!out_valid_h) lat = -1;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({alu_out, n_flag, z_flag, v_flag, out_valid, busy, in_ready} !== {32'h0, 5'b00000, 1'b1}) begin
      failures++;
      $display("FAIL reset32 got out=%h nzv=%b%b%b ov=%b busy=%b rdy=%b exp out=0 nzv=000 ov=0 busy=0 rdy=1",
               alu_out, n_flag, z_flag, v_flag, out_valid, busy, in_ready);
    end
    checks++;
    if ({alu_out_h, n_flag_h, z_flag_h, v_flag_h, out_valid_h, busy_h, in_ready_h} !== {16'h0, 5'b00000, 1'b1}) begin
      failures++;
      $display("FAIL reset16 got out=%h nzv=%b%b%b ov=%b busy=%b rdy=%b exp out=0 nzv=000 ov=0 busy=0 rdy=1",
               alu_out_h, n_flag_h, z_flag_h, v_flag_h, out_valid_h, busy_h, in_ready_h);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add_overflow;
    int lat; bit rs;
    op32(T_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, lat, rs);
    checks++;
    if ({lat, alu_out, n_flag, z_flag, v_flag, in_ready} !== {32'd1, 32'h8000_0000, 3'b101, 1'b0}) begin
      failures++;
      $display("FAIL add_ovf got lat=%0d out=%h nzv=%b%b%b rdy=%b exp lat=1 out=80000000 nzv=101 rdy=0",
               lat, alu_out, n_flag, z_flag, v_flag, in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if ({out_valid, in_ready, alu_out} !== {2'b01, 32'h8000_0000}) begin
      failures++;
      $display("FAIL add_pulse got ov=%b rdy=%b out=%h exp ov=0 rdy=1 out=80000000", out_valid, in_ready, alu_out);
    end
  endtask

  task automatic test_sub_shift;
    logic [5:0]  ops [6] = '{T_SUB, T_SLL, T_SLL, T_SRL, T_SUB, T_SUB};
    logic [31:0] xs  [6] = '{32'h5, 32'h1, 32'h1, 32'h8000_0000, 32'h8000_0000, 32'h0};
    logic [31:0] ys  [6] = '{32'h5, 32'h4, 32'd40, 32'd31, 32'h1, 32'h1};
    logic [31:0] eo  [6] = '{32'h0, 32'h10, 32'h0, 32'h1, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
    logic [2:0]  ef  [6] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b001, 3'b100};
    int lat; bit rs;
    for (int i = 0; i < 6; i++) begin
      op32(ops[i], xs[i], ys[i], 1'b0, lat, rs);
      checks++;
      if ({lat, alu_out, n_flag, z_flag, v_flag} !== {32'd1, eo[i], ef[i]}) begin
        failures++;
        $display("FAIL sub_shift[%0d] got lat=%0d out=%h nzv=%b%b%b exp lat=1 out=%h nzv=%b",
                 i, lat, alu_out, n_flag, z_flag, v_flag, eo[i], ef[i]);
      end
    end
  endtask

  task automatic test_logic;
    logic [5:0]  ops [5] = '{T_XOR, T_AND, T_ANDI, T_NAND, T_ADDI};
    logic [31:0] xs  [5] = '{32'hFF00_FF00, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 32'h1};
    logic [31:0] ys  [5] = '{32'h0F0F_0F0F, 32'h0FF0_0FF0, 32'h0FF0_0FF0, 32'hFFFF_FFFF, 32'h2};
    logic [31:0] eo  [5] = '{32'hF00F_F00F, 32'h00F0_00F0, 32'h00F0_00F0, 32'h0, 32'h3};
    logic [2:0]  ef  [5] = '{3'b100, 3'b000, 3'b000, 3'b010, 3'b000};
    int lat; bit rs;
    for (int i = 0; i < 5; i++) begin
      op32(ops[i], xs[i], ys[i], 1'b0, lat, rs);
      checks++;
      if ({lat, alu_out, n_flag, z_flag, v_flag} !== {32'd1, eo[i], ef[i]}) begin
        failures++;
        $display("FAIL logic[%0d] got lat=%0d out=%h nzv=%b%b%b exp lat=1 out=%h nzv=%b",
                 i, lat, alu_out, n_flag, z_flag, v_flag, eo[i], ef[i]);
      end
    end
  endtask

  // Multi-cycle ops: latency 33, in_ready never high while working,
  // junk in_valid pulses during the operation change nothing
  task automatic test_muldiv;
    logic [5:0]  ops [7] = '{T_MULT, T_MULT, T_MULT, T_DIV, T_DIV, T_DIV, T_DIV};
    logic [31:0] xs  [7] = '{32'h0000_FFFF, 32'h0001_0000, 32'h1234_5678, 32'h64,
                             32'h1234, 32'hFFFF_FFFF, 32'h5};
    logic [31:0] ys  [7] = '{32'h0001_0001, 32'h0001_0000, 32'h9, 32'h7,
                             32'h0, 32'h10, 32'h9};
    logic [31:0] eo  [7] = '{32'hFFFF_FFFF, 32'h0, 32'hA3D7_0A38, 32'hE,
                             32'hFFFF_FFFF, 32'h0FFF_FFFF, 32'h0};
    logic [2:0]  ef  [7] = '{3'b100, 3'b011, 3'b100, 3'b000, 3'b101, 3'b000, 3'b010};
    int lat; bit rs;
    for (int i = 0; i < 7; i++) begin
      op32(ops[i], xs[i], ys[i], 1'b1, lat, rs);
      checks++;
      if ({lat, alu_out, n_flag, z_flag, v_flag, rs} !== {32'd33, eo[i], ef[i], 1'b0}) begin
        failures++;
        $display("FAIL muldiv[%0d] got lat=%0d out=%h nzv=%b%b%b rdy_seen=%b exp lat=33 out=%h nzv=%b rdy_seen=0",
                 i, lat, alu_out, n_flag, z_flag, v_flag, rs, eo[i], ef[i]);
      end
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, busy} !== 3'b010) begin
        failures++;
        $display("FAIL muldiv_after[%0d] got ov=%b rdy=%b busy=%b exp ov=0 rdy=1 busy=0",
                 i, out_valid, in_ready, busy);
      end
    end
  endtask

  task automatic test_undefined;
    logic [5:0] ops [2] = '{T_NOP, 6'h10};
    int lat; bit rs;
    op32(T_ADD, 32'h7FFF_FFFF, 32'h1, 1'b0, lat, rs);
    for (int i = 0; i < 2; i++) begin
      op32(ops[i], 32'h0, 32'h0, 1'b0, lat, rs);
      checks++;
      if ({lat, alu_out, n_flag, z_flag, v_flag} !== {32'd1, 32'h8000_0000, 3'b101}) begin
        failures++;
        $display("FAIL undef[%0d] got lat=%0d out=%h nzv=%b%b%b exp lat=1 out=80000000 nzv=101",
                 i, lat, alu_out, n_flag, z_flag, v_flag);
      end
    end
  endtask

  task automatic test_reset_mid_div;
    int lat; bit rs; int pulses; int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    op = T_DIV; a = 32'd1000; b = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({alu_out, n_flag, z_flag, v_flag, out_valid, busy, in_ready} !== {32'h0, 5'b00000, 1'b1}) begin
      failures++;
      $display("FAIL rst_mid_div got out=%h nzv=%b%b%b ov=%b busy=%b rdy=%b exp out=0 nzv=000 ov=0 busy=0 rdy=1",
               alu_out, n_flag, z_flag, v_flag, out_valid, busy, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      failures++;
      $display("FAIL rst_no_pulse got pulses=%0d exp 0", pulses);
    end
    op32(T_ADD, 32'd2, 32'd3, 1'b0, lat, rs);
    checks++;
    if ({lat, alu_out, n_flag, z_flag, v_flag} !== {32'd1, 32'h5, 3'b000}) begin
      failures++;
      $display("FAIL rst_then_add got lat=%0d out=%h nzv=%b%b%b exp lat=1 out=00000005 nzv=000",
               lat, alu_out, n_flag, z_flag, v_flag);
    end
  endtask

  // in_valid held high: accepted every other cycle, result pulses alternate
  task automatic test_back_to_back;
    int guard; int pulses; logic [5:0] pattern;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    op = T_ADD; a = 32'd1; b = 32'd1; in_valid = 1'b1;
    pulses = 0;
    pattern = '0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      pattern[5-i] = out_valid;
      if (out_valid) pulses++;
    end
    in_valid = 1'b0;
    checks++;
    if ({pulses, pattern, alu_out} !== {32'd3, 6'b101010, 32'h2}) begin
      failures++;
      $display("FAIL back_to_back got pulses=%0d pattern=%b out=%h exp pulses=3 pattern=101010 out=00000002",
               pulses, pattern, alu_out);
    end
  endtask

  task automatic test_width16;
    logic [5:0]  ops [3] = '{T_ADD, T_MULT, T_MULT};
    logic [15:0] xs  [3] = '{16'h7FFF, 16'h00FF, 16'h0100};
    logic [15:0] ys  [3] = '{16'h0001, 16'h0101, 16'h0100};
    logic [15:0] eo  [3] = '{16'h8000, 16'hFFFF, 16'h0000};
    logic [2:0]  ef  [3] = '{3'b101, 3'b100, 3'b011};
    int          el  [3] = '{1, 17, 17};
    int lat;
    for (int i = 0; i < 3; i++) begin
      op16(ops[i], xs[i], ys[i], lat);
      checks++;
      if ({lat, alu_out_h, n_flag_h, z_flag_h, v_flag_h} !== {el[i], eo[i], ef[i]}) begin
        failures++;
        $display("FAIL w16[%0d] got lat=%0d out=%h nzv=%b%b%b exp lat=%0d out=%h nzv=%b",
                 i, lat, alu_out_h, n_flag_h, z_flag_h, v_flag_h, el[i], eo[i], ef[i]);
      end
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    op         = T_NOP;
    a          = '0;
    b          = '0;
    in_valid_h = 1'b0;
    op_h       = T_NOP;
    a_h        = '0;
    b_h        = '0;

    test_reset();
    test_add_overflow();
    test_sub_shift();
    test_logic();
    test_muldiv();
    test_undefined();
    test_reset_mid_div();
    test_back_to_back();
    test_width16();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor to the CPU's combinational ALU.
- Adds multi-cycle unsigned MULT and DIV using an iterative datapath.
- Adds a valid/ready operand handshake, a registered result and a sticky N/Z/V flag register.
- Sits in the CPU execute stage; the pipeline stalls on in_ready=0.

Parameters:
WIDTH, 32, datapath width in bits (≥8, even)
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  operands and op presented
in_ready  out  1  block can accept an operation (high only in IDLE)
op  in  6  opcode: ADD 00, ADDI 01, SUB 02, AND 03, ANDI 04, SLL 05, SRL 06, DIV 15, MULT 16, NAND 22, XOR 23, NO_OP 3F
alu_in1  in  WIDTH  operand A / value to shift / dividend
alu_in2  in  WIDTH  operand B / shift amount / divisor
alu_out  out  WIDTH  registered result
out_valid  out  1  one-cycle pulse: alu_out and flags updated this cycle
n_flag  out  1  negative flag (registered, sticky)
z_flag  out  1  zero flag (registered, sticky)
v_flag  out  1  overflow flag (registered, sticky)
busy  out  1  multi-cycle operation in progress

Behaviour:
- Reset, asynchronous: state=IDLE, alu_out=0, N=Z=V=0, out_valid=0, busy=0, in_ready=1.
- Accept: an operation is accepted on a rising edge with in_valid & in_ready. Operands and op are captured that edge; later input changes are ignored.
- States: IDLE, MUL, DIV, DONE.
  - IDLE → DONE for single-cycle ops, NO_OP and undefined opcodes.
  - IDLE → MUL on MULT.
  - IDLE → DIV on DIV.
  - MUL or DIV → DONE when the counter reaches WIDTH.
  - DONE → IDLE unconditionally.
  - out_valid=1 only in DONE.
  - in_ready=1 only in IDLE, so back-to-back single-cycle ops have a throughput of one per 2 cycles.
- Latency: accepted at edge t; single-cycle result valid during cycle t+1. MULT/DIV result valid during cycle t+WIDTH+1.
- ADD/ADDI: out = A+B mod 2^WIDTH. V = carry into MSB XOR carry out of MSB (signed overflow).
- SUB: out = A−B mod 2^WIDTH. V = signed overflow (A and B signs differ and result sign ≠ A sign).
- AND/ANDI/NAND/XOR: bitwise operation; V=0.
- N = out[WIDTH-1] and Z = (out==0) for every op except SLL, SRL, NO_OP and undefined opcodes.
- SLL/SRL: logical shift of A by the full unsigned value of B; B ≥ WIDTH gives 0. N/Z/V are left unchanged.
- MULT: unsigned shift-add, one bit per cycle, full 2·WIDTH product held internally. out = low WIDTH bits. V = (high half ≠ 0). N/Z from out.
- DIV: unsigned restoring division, one quotient bit per cycle. out = quotient.
  - B==0: out = all ones and V=1; the full WIDTH cycles still elapse.
  - Otherwise V=0.
  - N/Z from out.
- NO_OP and undefined opcodes: out_valid still pulses; alu_out and all flags hold their previous values.
- Flags and alu_out update only on the DONE-entry edge and otherwise hold.
- in_valid is ignored while not in IDLE; no queuing.
- Reset mid-MUL/DIV: the operation is aborted, no out_valid is produced, and all reset values apply immediately.

Decomposition:
- Shared package alu_pkg: opcode localparams (ADD…NO_OP) and state encoding (IDLE, MUL, DIV, DONE).
- Sub-module seq_alu_iter: iterative mul/div engine.
  - Inputs: start, is_div, A, B, clk, rst.
  - Outputs: done, lo/quotient, hi-nonzero, div-by-zero.
- Single-cycle ops and the flag logic stay in seq_alu.

Test Plan:
1. ADD 7FFFFFFF+00000001 → next cycle out=80000000, N=1, Z=0, V=1, out_valid pulse of 1 cycle.
2. SUB 5−5, then SLL 00000001 by 4 → first result out=0, Z=1, V=0; SLL out=00000010 with Z=1 retained (flags unchanged). SLL by 40 → out=0.
3. MULT 0000FFFF×00010001 → out_valid exactly 33 cycles after accept, out=FFFFFFFF, V=0, N=1. MULT 00010000×00010000 → out=0, V=1, Z=1.
4. DIV 00000064÷00000007 → out=0000000E after 33 cycles, V=0. DIV x÷0 → out=FFFFFFFF, V=1. in_ready stays 0 throughout and in_valid pulses during busy are ignored.
5. Assert rst at cycle 10 of a DIV → alu_out=0, flags=0, in_ready=1 asynchronously, no out_valid. A following ADD 2+3 → out=5.
6. Opcode 3F and opcode 10 → out_valid pulses, alu_out and N/Z/V unchanged. Rerun scenarios 1 and 3 with WIDTH=16: MULT latency 17 cycles, ADD 7FFF+1 sets V.
